// File: rtl/adc128s_pkg.sv
// Shared types and constants for the ADC128S SPI front end.
package adc128s_pkg;

  localparam int FRAME_W = 16;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop; yields the synchronized level
// and single-cycle rise/fall pulses for one asynchronous input pin.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic ff1_q;
  logic ff2_q;
  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q  <= RST_VAL;
      ff2_q  <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      ff1_q  <= pin_i;
      ff2_q  <= ff1_q;
      hist_q <= ff2_q;
    end
  end

  assign level_o = ff2_q;
  assign rise_o  = ff2_q & ~hist_q;
  assign fall_o  = ~ff2_q & hist_q;

endmodule

// File: rtl/spi_adc128s.sv
// SPI mode-3 slave for the ADC128S model: 16-bit command in, A2D word out.
// Define SPI_ADC128S_TRISTATE_EN to float MISO while the slave is idle.
module spi_adc128s
  import adc128s_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  input  logic [FRAME_W-1:0] A2D_data,
  output logic               MISO,
  output logic [FRAME_W-1:0] cmd,
  output logic               rdy
);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (SS_n),
    .level_o(ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (SCLK),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (MOSI),
    .level_o(mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  // Only the SS/SCLK edges and the MOSI level drive the datapath.
  logic unused_sync;
  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_t         state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] cmd_q, cmd_d;
  logic               rdy_q, rdy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          tx_d    = A2D_data;
          cnt_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      SHIFT: begin
        // SS_n rise takes priority; any SCLK edge in the same cycle is dropped.
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            cmd_d = rx_q;
            rdy_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q != CNT_FULL) begin
            rx_d  = {rx_q[FRAME_W-2:0], mosi_lvl};
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // The leading fall keeps bit 15 up for the first rise; trailing falls are surplus.
          if (cnt_q != '0 && cnt_q != CNT_FULL) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_ADC128S_TRISTATE_EN
  assign MISO = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'bz;
`else
  assign MISO = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'b0;
`endif

  assign cmd = cmd_q;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_spi_adc128s.sv
// Bench for spi_adc128s: table-driven SPI mode-3 frames with a scoreboard queue.
module tb_spi_adc128s;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [15:0] A2D_data;
  logic        MISO;
  logic [15:0] cmd;
  logic        rdy;

  spi_adc128s dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .A2D_data(A2D_data),
    .MISO    (MISO),
    .cmd     (cmd),
    .rdy     (rdy)
  );

`ifdef SPI_ADC128S_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mosi;
    logic [15:0] a2d;
    int          nbits;
    logic [15:0] exp_cmd;
    logic [15:0] exp_miso;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  int total = 0;
  int bad   = 0;
  int rises = 0;
  logic rdy_d1 = 1'b0;

  always @(posedge clk) begin
    rdy_d1 <= rdy;
    if (rdy === 1'b1 && rdy_d1 !== 1'b1) rises++;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Master side of one frame; SCLK idles high, MOSI changes on falls, MISO sampled before rises.
  task automatic run_frame(input logic [15:0] mosi_w, input logic [15:0] a2d, input int nbits,
                           input int chg_at, input logic [15:0] chg_val, input int rst_at,
                           output logic [15:0] miso_w);
    miso_w = '0;
    @(negedge clk);
    A2D_data = a2d;
    SS_n     = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdy_clr_at_ss_fall", {15'd0, rdy}, 16'd0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mosi_w[15-i];
      repeat (10) @(negedge clk);
      miso_w[15-i] = MISO;
      SCLK = 1'b1;
      if (i == chg_at) A2D_data = chg_val;
      if (i + 1 == rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_rdy", {15'd0, rdy}, 16'd0);
        chk("midrst_cmd", cmd, 16'h0000);
        chk("midrst_miso", {15'd0, MISO}, {15'd0, IDLE_MISO});
        rst_n = 1'b1;
      end
      repeat (10) @(negedge clk);
    end
    SS_n = 1'b1;
  endtask

  task automatic end_check(input string nm, input logic [15:0] miso_w, input int rises_before);
    vec_t e;
    int   lat;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got empty queue want entry", nm);
      return;
    end
    e   = sb.pop_front();
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1 && lat == 0) lat = k;
    end
    total++;
    if (e.exp_rdy) begin
      if (lat < 3 || lat > 4) begin
        bad++;
        $display("FAIL %s_rdy_lat: got %0d want 3..4", nm, lat);
      end
    end else if (lat != 0) begin
      bad++;
      $display("FAIL %s_no_rdy: got rdy after %0d want none", nm, lat);
    end
    chk({nm, "_cmd"}, cmd, e.exp_cmd);
    if (e.exp_rdy) chk({nm, "_miso_word"}, miso_w, e.exp_miso);
    chk({nm, "_rdy_rises"}, 16'(rises - rises_before), e.exp_rdy ? 16'd1 : 16'd0);
    chk({nm, "_miso_idle"}, {15'd0, MISO}, {15'd0, IDLE_MISO});
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [15:0] mw;
    int          r0;
    SS_n     = 1'b1;
    SCLK     = 1'b1;
    MOSI     = 1'b0;
    A2D_data = '0;
    rst_n    = 1'b0;

    vecs[0] = '{16'h2800, 16'h0C05, 16, 16'h2800, 16'h0C05, 1'b1};
    vecs[1] = '{16'h2000, 16'h1234,  8, 16'h2800, 16'h0000, 1'b0};
    vecs[2] = '{16'h0000, 16'hABCD, 16, 16'h0000, 16'hABCD, 1'b1};
    vecs[3] = '{16'h2000, 16'h5A5A, 16, 16'h2000, 16'h5A5A, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h8001, 16, 16'hFFFF, 16'h8001, 1'b1};

    repeat (5) @(negedge clk);
    chk("reset_rdy", {15'd0, rdy}, 16'd0);
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_miso", {15'd0, MISO}, {15'd0, IDLE_MISO});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sb.push_back(vecs[i]);
      r0 = rises;
      run_frame(vecs[i].mosi, vecs[i].a2d, vecs[i].nbits, -1, 16'h0, -1, mw);
      end_check($sformatf("vec%0d", i), mw, r0);
    end

    // A2D_data changes mid-frame; the word latched at SS_n fall must still go out.
    sb.push_back('{16'h2800, 16'h0C05, 16, 16'h2800, 16'h0C05, 1'b1});
    r0 = rises;
    run_frame(16'h2800, 16'h0C05, 16, 4, 16'h0BF4, -1, mw);
    end_check("a2d_change", mw, r0);
    sb.push_back('{16'h2000, 16'h0BF4, 16, 16'h2000, 16'h0BF4, 1'b1});
    r0 = rises;
    run_frame(16'h2000, 16'h0BF4, 16, -1, 16'h0, -1, mw);
    end_check("a2d_next", mw, r0);

    // Reset pulse after 5 SCLK cycles abandons the frame.
    sb.push_back('{16'h2800, 16'h0C05, 16, 16'h0000, 16'h0000, 1'b0});
    r0 = rises;
    run_frame(16'h2800, 16'h0C05, 16, -1, 16'h0, 5, mw);
    end_check("mid_reset", mw, r0);
    sb.push_back('{16'h3800, 16'h0777, 16, 16'h3800, 16'h0777, 1'b1});
    r0 = rises;
    run_frame(16'h3800, 16'h0777, 16, -1, 16'h0, -1, mw);
    end_check("post_reset", mw, r0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_adc128s.md
# spi_adc128s

SPI slave front end for the ADC128S 12-bit A2D converter model. It receives a 16-bit command frame from the SPI master (SPI mode 3), returns a 16-bit data word during the same frame, and presents the received command plus a completion flag to the ADC core. The core parses `cmd[13:11]` as the channel and supplies `A2D_data`.

## Interface
- No parameters. Frame width is fixed at 16 bits.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `SS_n` input, 1 bit: active-low slave select, asynchronous to `clk`.
- `SCLK` input, 1 bit: serial clock. Idles high. Asynchronous to `clk`.
- `MOSI` input, 1 bit: serial command data, MSB first.
- `A2D_data` input, 16 bits: word to return in the current frame.
- `MISO` output, 1 bit: serial response data, MSB first.
- `cmd` output, 16 bits: last complete command received.
- `rdy` output, 1 bit: high from a valid frame end until the next frame start.

## Operation
- `SS_n`, `SCLK` and `MOSI` each pass through a 2-flop synchronizer plus one history flop for edge detection. All logic runs on `clk`.
- State machine:
  - IDLE → SHIFT on synchronized `SS_n` fall.
  - SHIFT → IDLE on synchronized `SS_n` rise.
- Frame start (`SS_n` fall), all in the same cycle:
  - TX shift register loads `A2D_data`.
  - Bit counter clears.
  - `rdy` clears.
  - `A2D_data` is sampled only at this point; changes during a frame are ignored.
- `MISO` = TX[15] whenever in SHIFT.
- SCLK rise in SHIFT: shift synchronized `MOSI` into the RX register LSB and increment the bit counter. The counter saturates at 16.
- SCLK fall in SHIFT: shift TX left by one.
  - The first fall after frame start is ignored, so bit 15 stays valid through the first rise.
  - Falls after the 16th rise are also ignored.
- Frame end (`SS_n` rise):
  - Counter == 16: `cmd` ← RX and `rdy` set.
  - Counter ≠ 16 (short or aborted frame): `cmd` unchanged, `rdy` stays 0.
- `rdy` is a level signal. It rises exactly once per valid frame, so a rising-edge detector in the consumer sees one event per frame.
- Reset, including mid-frame: state IDLE, `cmd` = 16'h0000, `rdy` = 0, TX/RX/counter = 0, synchronizers reset to idle values (`SS_n`/`SCLK` = 1, `MOSI` = 0). A frame in progress is abandoned.

## Timing
- Synchronized edges act 3 `clk` cycles after the pin edge.
- `MISO` updates 3–4 `clk` cycles after an `SCLK` fall. Bit 15 is valid 3–4 cycles after the `SS_n` fall.
- `cmd`/`rdy` update 3–4 `clk` cycles after the `SS_n` rise.
- Constraints on the master:
  - SCLK high and low phases ≥ 8 `clk` cycles each.
  - `SS_n` setup to the first `SCLK` fall ≥ 8 `clk` cycles.
  - `SS_n` hold after the last `SCLK` rise ≥ 8 `clk` cycles.
  - `SS_n` high between frames ≥ 8 `clk` cycles.
- If an `SS_n` rise and an `SCLK` edge are detected in the same cycle, the `SS_n` rise wins and that `SCLK` edge is discarded.

## Configuration
- `SPI_ADC128S_TRISTATE_EN`:
  - Defined: `MISO` is high-impedance (`'z`) in IDLE, for a shared MISO bus.
  - Undefined: `MISO` is driven 0 in IDLE.
- SHIFT behaviour is the same either way.

## Structure
- Shared package `adc128s_pkg` holds:
  - `localparam FRAME_W = 16`
  - the state typedef `spi_state_t {IDLE, SHIFT}`
  - the counter width constant.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus history flop, one per input pin.
  - Reset value is a port-level constant.
  - Outputs: synchronized level, rise pulse, fall pulse.

## Test plan
- Reset: assert `rst_n` = 0 mid-operation → `rdy` = 0, `cmd` = 16'h0000. `MISO` = `'z` with the macro, 0 without. A new full frame afterwards completes normally.
- Full frame: `MOSI` = 16'h2800, `A2D_data` = 16'h0C05 → master receives 16'h0C05 MSB first; `cmd` = 16'h2800 and `rdy` rises once, 3–4 cycles after the `SS_n` rise.
- `A2D_data` changed from 16'h0C05 to 16'h0BF4 mid-frame → master still receives 16'h0C05; the next frame returns 16'h0BF4.
- Short frame of 8 SCLK cycles with `MOSI` = 16'h2000 → `cmd` keeps its prior value, `rdy` stays 0.
- Back-to-back frames with 16'h0000 then 16'h2000 → `rdy` falls at the second `SS_n` fall and rises again at its end; `cmd` = 16'h2000.
- `rst_n` pulsed after 5 SCLK cycles → `rdy` = 0, `cmd` = 16'h0000, no `rdy` at that frame's `SS_n` rise.
